// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS pipeline. It captures the ID operands and
// control, forwards from MEM at capture time, flags EX->EX bypass and inserts load-use bubbles.
module id_ex_stage #(
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_dst,
  input  logic [31:0]       id_rd1,
  input  logic [31:0]       id_rd2,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_regwr,
  input  logic              id_memrd,
  input  logic              flush,
  input  logic              exmem_regwr,
  input  logic              exmem_memrd,
  input  logic [4:0]        exmem_dst,
  input  logic [31:0]       exmem_alu,
  input  logic [31:0]       mem_ldata,
  output logic              ex_valid,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dst,
  output logic [31:0]       ex_op1,
  output logic [31:0]       ex_op2,
  output logic [31:0]       ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_regwr,
  output logic              ex_memrd,
  output logic              ex_fwd_a,
  output logic              ex_fwd_b,
  output logic              stall
);

  logic              ex_valid_q, ex_regwr_q, ex_memrd_q, ex_fwd_a_q, ex_fwd_b_q;
  logic [4:0]        ex_rs_q, ex_rt_q, ex_dst_q;
  logic [31:0]       ex_op1_q, ex_op2_q, ex_imm_q;
  logic [CTRL_W-1:0] ex_ctrl_q;

  logic              stall_d, kill_d, fwd_a_d, fwd_b_d;
  logic [31:0]       op1_d, op2_d, mem_fwd_d;

  // Register 0 is hard-wired to zero, so it never takes part in bypass or hazard checks.
  function automatic logic match(input logic [4:0] r, input logic [4:0] d);
    return (r != 5'd0) && (r == d);
  endfunction

  always_comb begin
    stall_d   = id_valid & ex_valid_q & ex_memrd_q &
                (match(id_rs, ex_dst_q) | match(id_rt, ex_dst_q)) & ~flush;
    kill_d    = flush | stall_d;
    fwd_a_d   = id_valid & ex_valid_q & ex_regwr_q & ~ex_memrd_q & match(id_rs, ex_dst_q);
    fwd_b_d   = id_valid & ex_valid_q & ex_regwr_q & ~ex_memrd_q & match(id_rt, ex_dst_q);
    mem_fwd_d = exmem_memrd ? mem_ldata : exmem_alu;
    op1_d     = id_rd1;
    op2_d     = id_rd2;
    // When the EX bypass flag is set the captured operand is ignored downstream.
    if (exmem_regwr && match(id_rs, exmem_dst)) op1_d = mem_fwd_d;
    if (exmem_regwr && match(id_rt, exmem_dst)) op2_d = mem_fwd_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q <= 1'b0;
      ex_regwr_q <= 1'b0;
      ex_memrd_q <= 1'b0;
      ex_fwd_a_q <= 1'b0;
      ex_fwd_b_q <= 1'b0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_dst_q   <= '0;
      ex_op1_q   <= '0;
      ex_op2_q   <= '0;
      ex_imm_q   <= '0;
      ex_ctrl_q  <= '0;
    end else begin
      // A killed slot only clears the qualifying bits; data fields are don't-care.
      ex_valid_q <= id_valid & ~kill_d;
      ex_regwr_q <= id_valid & id_regwr & ~kill_d;
      ex_memrd_q <= id_valid & id_memrd & ~kill_d;
      ex_fwd_a_q <= fwd_a_d & ~kill_d;
      ex_fwd_b_q <= fwd_b_d & ~kill_d;
      ex_rs_q    <= id_rs;
      ex_rt_q    <= id_rt;
      ex_dst_q   <= id_dst;
      ex_op1_q   <= op1_d;
      ex_op2_q   <= op2_d;
      ex_imm_q   <= id_imm;
      ex_ctrl_q  <= id_ctrl;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_regwr = ex_regwr_q;
  assign ex_memrd = ex_memrd_q;
  assign ex_fwd_a = ex_fwd_a_q;
  assign ex_fwd_b = ex_fwd_b_q;
  assign ex_rs    = ex_rs_q;
  assign ex_rt    = ex_rt_q;
  assign ex_dst   = ex_dst_q;
  assign ex_op1   = ex_op1_q;
  assign ex_op2   = ex_op2_q;
  assign ex_imm   = ex_imm_q;
  assign ex_ctrl  = ex_ctrl_q;
  assign stall    = stall_d;

endmodule
